// File: rtl/counting_signals_popcount4.sv
// counting_signals_popcount4: combinational count of high bits among four 1-bit inputs (0..4).
module counting_signals_popcount4 (
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_c,
    input  logic       i_d,
    output logic [2:0] o_cnt
);
    assign o_cnt = {2'b00, i_a} + {2'b00, i_b} + {2'b00, i_c} + {2'b00, i_d};
endmodule

// File: rtl/counting_signals.sv
// counting_signals: switch-gated popcount of in0..in3 with a registered copy and a post-reset valid flag.
module counting_signals (
    input  logic       clk,
    input  logic       rst,
    input  logic       switch,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    output logic [2:0] out,
    output logic [2:0] out_q,
    output logic       out_vld
);
    localparam int CNT_W = 3;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] r_q;
    logic             r_vld;
    counting_signals_popcount4 u_pop (
        .i_a   (in0),
        .i_b   (in1),
        .i_c   (in2),
        .i_d   (in3),
        .o_cnt (w_cnt)
    );
    // Disabled means driven zero; out stays live through reset.
    assign out = switch ? w_cnt : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            r_vld <= 1'b0;
        end else begin
            r_q   <= out;
            r_vld <= 1'b1;
        end
    end
    assign out_q   = r_q;
    assign out_vld = r_vld;
endmodule

// File: tb/tb_counting_signals.sv
// tb_counting_signals: directed self-checking bench for counting_signals.
module tb_counting_signals;
    logic       clk = 1'b0;
    logic       rst, switch, in0, in1, in2, in3;
    logic [2:0] out, out_q;
    logic       out_vld;
    int         n_vec = 0;
    int         n_err = 0;
    logic [2:0] exp_tab [16] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd1, 3'd2, 3'd2, 3'd3,
                                 3'd1, 3'd2, 3'd2, 3'd3, 3'd2, 3'd3, 3'd3, 3'd4};

    counting_signals dut (
        .clk     (clk),
        .rst     (rst),
        .switch  (switch),
        .in0     (in0),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .out     (out),
        .out_q   (out_q),
        .out_vld (out_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v);
        {in3, in2, in1, in0} = v;
    endtask

    initial begin
        rst = 1'b1;
        switch = 1'b1;
        drive(4'b0000);
        #1;
        chk("rst_out_q", out_q, 3'd0);
        chk("rst_out_vld", {2'b00, out_vld}, 3'd0);
        for (int i = 0; i < 16; i++) begin
            drive(4'(i));
            #2;
            chk($sformatf("sweep_%0d", i), out, exp_tab[i]);
        end
        switch = 1'b0;
        drive(4'b1111);
        #1 chk("off_1111", out, 3'd0);
        drive(4'b0101);
        #1 chk("off_0101", out, 3'd0);
        switch = 1'b1;
        #1 chk("on_0101", out, 3'd2);
        drive(4'b1011);
        @(negedge clk);
        chk("held_rst_q", out_q, 3'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_q", out_q, 3'd3);
        chk("first_vld", {2'b00, out_vld}, 3'd1);
        drive(4'b1111);
        #1;
        chk("out_now4", out, 3'd4);
        chk("q_still3", out_q, 3'd3);
        @(posedge clk);
        #1;
        chk("q_4", out_q, 3'd4);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_q", out_q, 3'd0);
        chk("mid_rst_vld", {2'b00, out_vld}, 3'd0);
        chk("mid_rst_out", out, 3'd4);
        drive(4'b0111);
        #1 chk("in3_lo", out, 3'd3);
        drive(4'b1111);
        #1 chk("in3_hi", out, 3'd4);
        drive(4'b0111);
        #1 chk("in3_lo2", out, 3'd3);
        drive(4'b1000);
        #1 chk("only_in3", out, 3'd1);
        @(posedge clk);
        #1 chk("rst_hold_q", out_q, 3'd0);
        drive(4'b1110);
        @(negedge clk);
        rst = 1'b0;
        switch = 1'b0;
        @(posedge clk);
        #1;
        chk("sw_off_q", out_q, 3'd0);
        chk("sw_off_vld", {2'b00, out_vld}, 3'd1);
        switch = 1'b1;
        #1 chk("sw_on_q_wait", out_q, 3'd0);
        @(posedge clk);
        #1 chk("sw_on_q", out_q, 3'd3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
